avalon_mem_responder: RTL

AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

---
 rtl/avalon_mem_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/avalon_mem_responder.sv
// rtl/avalon_mem_responder.sv - Avalon-MM byte memory responder with programmable wait states
module avalon_mem_responder #(
    parameter int MEM_DEPTH   = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [7:0]  avs_s0_writedata,
    output logic [7:0]  avs_s0_readdata,
    output logic        avs_s0_waitrequest,
    output logic [7:0]  err_count
);

    localparam int          AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(MEM_DEPTH);
    localparam logic [3:0]  WAIT_LD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic [7:0] mem [MEM_DEPTH];

    logic          req;
    logic          in_range;
    logic          both;
    logic [AW-1:0] idx;
    logic [7:0]    rd_value;

    assign req      = avs_s0_read | avs_s0_write;
    assign both     = avs_s0_read & avs_s0_write;
    assign in_range = (avs_s0_address < DEPTH_W);
    assign idx      = avs_s0_address[AW-1:0];

    // Range check gates every use of idx, so high address bits never alias.
    always_comb begin
        rd_value = 8'h00;
        if (both)
            rd_value = 8'h00;
        else if (!in_range)
            rd_value = 8'hFF;
        else
            rd_value = mem[idx];
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LD;
                    end
                end
            end
            S_WAIT: begin
                // A master that drops its request here has aborted the transfer.
                if (!req) begin
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = 4'd0;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt = S_ACK;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign avs_s0_waitrequest = req && (state != S_ACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            wait_cnt        <= 4'd0;
            avs_s0_readdata <= 8'h00;
            err_count       <= 8'h00;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == S_ACK && avs_s0_read)
                avs_s0_readdata <= rd_value;
            if (state == S_ACK && req && (!in_range || both) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    // Storage has no reset; an async reset forces IDLE so a pending write cannot commit.
    always_ff @(posedge clk) begin
        if (state == S_ACK && avs_s0_write && in_range)
            mem[idx] <= avs_s0_writedata;
    end

endmodule
